l0_pool: RTL and testbench
==========================

# l0_pool

2x2 stride-2 signed max-pool stage directly downstream of the layer-0 feature-map RAM (26x26 entries, 18-bit). On `start` it walks the 169 non-overlapping 2x2 windows in raster order. For each window it drives the RAM read address of the window's bottom-right pixel, takes the four window values the RAM returns combinationally, and writes their signed maximum into a 13x13 pooled output stream with a write strobe and linear address. One window is consumed per cycle.

## Interface
- `DATA_W`, 18: sample width, signed two's complement.
- `IN_DIM`, 26: input map side; must be even. `OUT_DIM` = `IN_DIM`/2 = 13.
- `clk` input 1: clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: single-cycle request to pool one full map; honoured only in IDLE.
- `rd` output 1: read enable to feature RAM; high exactly in RUN.
- `addr_rd` output 10: RAM address of the window's bottom-right pixel.
- `din` input 4 x `DATA_W` (`din[3:0]`): window values, same cycle as `addr_rd`. Order: [0] = addr-27 (top-left), [1] = addr-26 (top-right), [2] = addr-1 (bottom-left), [3] = addr (bottom-right).
- `pool_wr` output 1: pooled-sample write strobe.
- `pool_addr` output 8: linear pooled index, 0..168.
- `pool_dout` output `DATA_W`: pooled sample.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: one-cycle pulse after the last window is issued.

## Operation
- FSM states:
  - IDLE: `start`=1 moves to RUN, with row=0, col=0, `addr_rd`=27.
  - RUN: one window per cycle; moves to DONE after the cycle that issues row=12, col=12.
  - DONE: one cycle, then back to IDLE.
- Address generation is incremental, with no multiplier:
  - Within a row, `addr_rd` advances by 2.
  - At col=12 it advances by 28, to the next row's base.
  - Sequence: 27, 29, …, 51, 79, …, 675. Final address is 675, the last RAM entry.
- Index counter `idx` runs 0..168, advancing with each window.
- Max: `pool_dout` is the signed maximum of `din[0..3]`. On ties any equal value is acceptable, since the bit pattern is identical. Comparison is full `DATA_W` signed; no saturation or truncation.
- `start` in RUN or DONE is ignored; no queuing.
- `rd` low in IDLE/DONE. `addr_rd` holds its last value outside RUN, and the RAM output is don't-care then.
- Reset, including mid-RUN, aborts immediately: FSM to IDLE, counters 0. No partial `done`; a new `start` restarts from window 0.

## Timing
- Reset values: `rd`=0, `addr_rd`=0, `pool_wr`=0, `pool_addr`=0, `pool_dout`=0, `busy`=0, `done`=0.
- `start` sampled high at edge E gives RUN from E; the first `rd`/`addr_rd`=27 appears in the cycle after E.
- Latency is 1 cycle. The max of the window issued in cycle k is registered at the end of k; `pool_wr`=1 with its `pool_addr`/`pool_dout` in cycle k+1.
- RUN lasts exactly 169 cycles; `pool_wr` is high for 169 consecutive cycles, offset by one.
- The last write (`pool_addr`=168) coincides with the DONE cycle; `done`=1 in that same cycle.
- `pool_addr`/`pool_dout` hold their values when `pool_wr`=0.
- Back-to-back: `start` asserted in the cycle after DONE gives a one-cycle IDLE gap. Minimum period is 171 cycles per map.

## Structure
- Shared package `cnn_pkg`:
  - `DATA_W`, `L0_DIM`=26, `L1_DIM`=13.
  - Derived address widths.
  - FSM state enum `pool_state_t` {IDLE, RUN, DONE}.
- Sub-module `max4`: purely combinational signed 4-input maximum, built as a two-level compare tree, parameterised by `DATA_W`. Reused by later pool layers.

## Test plan
- Ramp map: RAM[i] = i. Run one full pass and expect:
  - 169 writes, `pool_addr` 0..168.
  - `pool_dout[0]`=27, `pool_dout[12]`=51, `pool_dout[168]`=675.
  - `done` coincides with write 168.
- Signed data: window 0 = {-5, -1, -131072, -2} gives `pool_dout`=-1 (0x3FFFF). A window of four equal values 0x1FFFF gives 0x1FFFF.
- Address trace: log `addr_rd` over RUN. It must equal 27+52r+2c for all r,c in 0..12, with `rd` high exactly 169 cycles.
- `start` pulsed again at RUN cycles 5 and 168: ignored, no extra writes. `start` in the cycle after DONE: a second full pass with identical output.
- `rst_n` low at RUN cycle 80: outputs return to their reset values immediately and `done` never pulses. A new `start` gives a full 169-write pass from `pool_addr`=0.
- Reset held through `start`: no activity; `busy` stays 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: sample width, map geometry, derived
// address widths and the pooling FSM state type.
package cnn_pkg;

    localparam int DATA_W = 18;
    localparam int L0_DIM = 26;
    localparam int L1_DIM = 13;

    localparam int L0_AW = $clog2(L0_DIM * L0_DIM);
    localparam int L1_AW = $clog2(L1_DIM * L1_DIM);
    localparam int L1_CW = $clog2(L1_DIM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pool_state_t;

endpackage

// File: rtl/l0_pool_if.sv
// Feature-RAM read port plus pooled-sample write stream of the layer-0 pool.
interface l0_pool_if
    import cnn_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = L0_AW,
    parameter int PW = L1_AW
);

    logic                   rd;
    logic [AW-1:0]          addr_rd;
    logic [3:0][DW-1:0]     din;
    logic                   pool_wr;
    logic [PW-1:0]          pool_addr;
    logic [DW-1:0]          pool_dout;

    modport master (
        output rd, addr_rd, pool_wr, pool_addr, pool_dout,
        input  din
    );

    modport slave (
        input  rd, addr_rd, pool_wr, pool_addr, pool_dout,
        output din
    );

endinterface

// File: rtl/max4.sv
// Combinational signed maximum of four samples as a two-level compare tree.
module max4 #(
    parameter int DATA_W = 18
) (
    input  logic [3:0][DATA_W-1:0] din,
    output logic [DATA_W-1:0]      max_out
);

    logic [1:0][DATA_W-1:0] pair_max;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pair
            assign pair_max[gi] = ($signed(din[2*gi]) > $signed(din[2*gi+1]))
                                  ? din[2*gi] : din[2*gi+1];
        end
    endgenerate

    assign max_out = ($signed(pair_max[0]) > $signed(pair_max[1]))
                     ? pair_max[0] : pair_max[1];

endmodule

// File: rtl/l0_pool.sv
// 2x2 stride-2 signed max-pool over the layer-0 feature map, one window per
// cycle, with the pooled result registered one cycle after its RAM read.
module l0_pool
    import cnn_pkg::*;
#(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int IN_DIM = L0_DIM
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    l0_pool_if.master      bus
);

    localparam int OUT_DIM = IN_DIM / 2;

    localparam logic [L1_CW-1:0] LAST_POS   = L1_CW'(OUT_DIM - 1);
    localparam logic [L0_AW-1:0] ADDR_FIRST = L0_AW'(IN_DIM + 1);
    localparam logic [L0_AW-1:0] ADDR_COL   = L0_AW'(2);
    // From the last window of a row, skip the odd row to reach the next base.
    localparam logic [L0_AW-1:0] ADDR_ROW   = L0_AW'(IN_DIM + 2);

    pool_state_t        state_reg;
    logic [L1_CW-1:0]   row_reg;
    logic [L1_CW-1:0]   col_reg;
    logic [L1_AW-1:0]   idx_reg;
    logic [L0_AW-1:0]   addr_reg;
    logic               rd_reg;
    logic               wr_reg;
    logic [L1_AW-1:0]   paddr_reg;
    logic [DATA_W-1:0]  pdout_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [DATA_W-1:0]  win_max;

    max4 #(.DATA_W(DATA_W)) u_max4 (
        .din     (bus.din),
        .max_out (win_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            col_reg   <= '0;
            idx_reg   <= '0;
            addr_reg  <= '0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            paddr_reg <= '0;
            pdout_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    wr_reg   <= 1'b0;
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg <= RUN;
                        rd_reg    <= 1'b1;
                        busy_reg  <= 1'b1;
                        addr_reg  <= ADDR_FIRST;
                        row_reg   <= '0;
                        col_reg   <= '0;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    wr_reg    <= 1'b1;
                    paddr_reg <= idx_reg;
                    pdout_reg <= win_max;
                    if (row_reg == LAST_POS && col_reg == LAST_POS) begin
                        // Last write lands in DONE, so done flags it directly.
                        state_reg <= DONE;
                        rd_reg    <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                        if (col_reg == LAST_POS) begin
                            col_reg  <= '0;
                            row_reg  <= row_reg + 1'b1;
                            addr_reg <= addr_reg + ADDR_ROW;
                        end else begin
                            col_reg  <= col_reg + 1'b1;
                            addr_reg <= addr_reg + ADDR_COL;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    wr_reg    <= 1'b0;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    row_reg   <= '0;
                    col_reg   <= '0;
                    idx_reg   <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                    rd_reg    <= 1'b0;
                    wr_reg    <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd        = rd_reg;
    assign bus.addr_rd   = addr_reg;
    assign bus.pool_wr   = wr_reg;
    assign bus.pool_addr = paddr_reg;
    assign bus.pool_dout = pdout_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;

endmodule

// File: tb/tb_l0_pool.sv
// Randomised scoreboard bench for l0_pool: a feature-RAM model feeds the
// window, expected reads and writes are queued at start and popped by a monitor.
module tb_l0_pool;

    localparam int DIM  = 26;
    localparam int ODIM = 13;
    localparam int NWIN = ODIM * ODIM;

    typedef struct {
        int          addr;
        logic [17:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy;
    logic done;

    l0_pool_if bus ();

    l0_pool dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic signed [17:0] ram [DIM*DIM];
    logic [17:0]        got      [NWIN];
    logic [17:0]        got_prev [NWIN];

    wr_t wr_q[$];
    int  addr_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  rd_cnt   = 0;
    int  wr_cnt   = 0;
    int  done_cnt = 0;

    // RAM returns the four window pixels combinationally from the read address.
    always_comb begin
        int a;
        a = int'(bus.addr_rd);
        bus.din = '0;
        if (a >= DIM + 1 && a < DIM * DIM) begin
            bus.din[0] = ram[a - DIM - 1];
            bus.din[1] = ram[a - DIM];
            bus.din[2] = ram[a - 1];
            bus.din[3] = ram[a];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: window (r,c) covers rows 2r..2r+1, cols 2c..2c+1 of the map.
    task automatic push_model();
        for (int r = 0; r < ODIM; r++) begin
            for (int c = 0; c < ODIM; c++) begin
                int  best;
                wr_t w;
                best = int'(ram[(2*r)*DIM + 2*c]);
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++)
                        if (int'(ram[(2*r+dy)*DIM + 2*c+dx]) > best)
                            best = int'(ram[(2*r+dy)*DIM + 2*c+dx]);
                w.addr = r * ODIM + c;
                w.data = best[17:0];
                wr_q.push_back(w);
                addr_q.push_back((2*r+1)*DIM + (2*c+1));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rd) begin
                rd_cnt++;
                if (addr_q.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("addr_rd", 32'(bus.addr_rd), 32'(addr_q.pop_front()));
            end
            if (bus.pool_wr) begin
                wr_cnt++;
                if (int'(bus.pool_addr) < NWIN) got[bus.pool_addr] = bus.pool_dout;
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    $display("write addr=%0d dout=0x%05h exp_addr=%0d exp_dout=0x%05h",
                             bus.pool_addr, bus.pool_dout, w.addr, w.data);
                    chk("pool_addr", 32'(bus.pool_addr), 32'(w.addr));
                    chk("pool_dout", 32'(bus.pool_dout), 32'(w.data));
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_with_last_wr", {31'd0, bus.pool_wr}, 1);
                chk("done_wr_addr", 32'(bus.pool_addr), NWIN - 1);
            end
        end
    end

    task automatic start_pass();
        rd_cnt   = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        push_model();
    endtask

    task automatic wait_done(input bit poke_start);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != 0) break;
            if (poke_start && (rd_cnt == 5 || rd_cnt == 168)) begin
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
    endtask

    task automatic end_checks();
        chk("wr_count", wr_cnt, NWIN);
        chk("rd_count", rd_cnt, NWIN);
        chk("done_count", done_cnt, 1);
        chk("wr_q_left", wr_q.size(), 0);
        chk("addr_q_left", addr_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rd"},        {31'd0, bus.rd}, 0);
        chk({tag, "_addr_rd"},   32'(bus.addr_rd), 0);
        chk({tag, "_pool_wr"},   {31'd0, bus.pool_wr}, 0);
        chk({tag, "_pool_addr"}, 32'(bus.pool_addr), 0);
        chk({tag, "_pool_dout"}, 32'(bus.pool_dout), 0);
        chk({tag, "_busy"},      {31'd0, busy}, 0);
        chk({tag, "_done"},      {31'd0, done}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        for (int i = 0; i < DIM*DIM; i++) ram[i] = 18'(i);
        // Reset held while start is asserted: nothing must happen.
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Ramp map with ignored start pulses mid-run and on the last window.
        start_pass();
        wait_done(1'b1);
        end_checks();
        chk("ramp_dout0", 32'(got[0]), 27);
        chk("ramp_dout12", 32'(got[12]), 51);
        chk("ramp_dout168", 32'(got[168]), 675);
        for (int i = 0; i < NWIN; i++) got_prev[i] = got[i];

        // Back-to-back pass, start in the single IDLE cycle after DONE.
        @(negedge clk);
        #1;
        chk("idle_gap_busy", {31'd0, busy}, 0);
        start_pass();
        wait_done(1'b0);
        end_checks();
        begin
            int diff = 0;
            for (int i = 0; i < NWIN; i++) if (got[i] !== got_prev[i]) diff++;
            chk("repeat_identical", diff, 0);
        end

        // Signed windows: mixed negatives and the largest positive value.
        @(negedge clk);
        #1;
        for (int i = 0; i < DIM*DIM; i++) ram[i] = 18'($urandom);
        ram[0]  = -18'sd5;
        ram[1]  = -18'sd1;
        ram[26] = -18'sd131072;
        ram[27] = -18'sd2;
        ram[2]  = 18'sh1FFFF;
        ram[3]  = 18'sh1FFFF;
        ram[28] = 18'sh1FFFF;
        ram[29] = 18'sh1FFFF;
        start_pass();
        wait_done(1'b0);
        end_checks();
        chk("signed_neg_max", 32'(got[0]), 32'h3FFFF);
        chk("signed_eq_max", 32'(got[1]), 32'h1FFFF);

        // Reset in the middle of a run aborts without a done pulse.
        @(negedge clk);
        #1;
        for (int i = 0; i < DIM*DIM; i++) ram[i] = 18'($urandom);
        start_pass();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (rd_cnt >= 80) break;
        end
        chk("abort_rd_cnt", rd_cnt, 80);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        wr_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        chk("abort_busy", {31'd0, busy}, 0);

        // Fresh random pass after the abort must start again at window 0.
        for (int i = 0; i < DIM*DIM; i++) ram[i] = 18'($urandom);
        start_pass();
        wait_done(1'b0);
        end_checks();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
